digit_scan_driver: RTL and testbench

Parametrised multiplexing driver for N-digit seven-segment displays, the successor of the fixed 8-digit anode driver. It time-slices a configurable number of digits, inserts a dead-time blanking window between digits to remove ghosting, skips masked digits, and dims the active digit by PWM. It sits between the display data path, which uses `anode_sel` to pick the digit's segment pattern, and the board anode pins.

---
 rtl/digit_scan_pkg.sv | 22 ++
 rtl/digit_scan_driver_slot_timer.sv | 42 ++++
 rtl/digit_scan_driver.sv | 134 +++++++++++++
 tb/tb_digit_scan_driver.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/digit_scan_pkg.sv
// Shared types and helpers for the multiplexed seven-segment digit scanner.
package digit_scan_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DEAD = 2'd1,
    ON   = 2'd2
  } scan_state_t;

  localparam int unsigned MAX_DIGITS = 16;

  // Inactive anode vector for n digits: all ones for common anode, else zeros.
  function automatic logic [MAX_DIGITS-1:0] anode_off(input int n, input bit active_low);
    logic [MAX_DIGITS-1:0] v;
    v = '0;
    for (int i = 0; i < int'(MAX_DIGITS); i++) begin
      if (i < n) v[i] = active_low;
    end
    return v;
  endfunction

endpackage

// File: rtl/digit_scan_driver_slot_timer.sv
// Per-slot cycle counter: flags the end of dead time and of the slot, and
// exposes the low counter bits of the coming cycle as the PWM phase.
module scan_slot_timer #(
  parameter int unsigned SLOT_CYCLES = 16384,
  parameter int unsigned DEAD_CYCLES = 64,
  parameter int unsigned BRIGHT_W    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                en,
  output logic                dead_done,
  output logic                slot_last,
  output logic [BRIGHT_W-1:0] pwm_phase_c
);

  localparam int unsigned CW = $clog2(SLOT_CYCLES);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;

  // Next count: clear wins, otherwise count and wrap at the slot end.
  always_comb begin
    cnt_nxt = cnt;
    if (clr) begin
      cnt_nxt = '0;
    end else if (en) begin
      cnt_nxt = (cnt == CW'(SLOT_CYCLES - 1)) ? '0 : cnt + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= '0;
    else     cnt <= cnt_nxt;
  end

  assign dead_done   = (cnt == CW'(DEAD_CYCLES - 1));
  assign slot_last   = (cnt == CW'(SLOT_CYCLES - 1));
  assign pwm_phase_c = cnt_nxt[BRIGHT_W-1:0];

endmodule

// File: rtl/digit_scan_driver.sv
// N-digit seven-segment scan driver with dead-time blanking, digit masking
// and optional PWM dimming. Define DIGIT_SCAN_PWM_EN to build the PWM;
// without it the brightness input is ignored and ON is fully lit.
module digit_scan_driver
  import digit_scan_pkg::*;
#(
  parameter int unsigned N_DIGITS    = 8,
  parameter int unsigned SLOT_CYCLES = 16384,
  parameter int unsigned DEAD_CYCLES = 64,
  parameter int unsigned ACTIVE_LOW  = 1,
  parameter int unsigned BRIGHT_W    = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic [N_DIGITS-1:0]         digit_mask,
  input  logic [BRIGHT_W-1:0]         brightness,
  output logic [$clog2(N_DIGITS)-1:0] anode_sel,
  output logic [N_DIGITS-1:0]         anodos,
  output logic                        blank,
  output logic                        frame_tick
);

  localparam int unsigned SW = $clog2(N_DIGITS);
  localparam logic [MAX_DIGITS-1:0] OFF_ALL = anode_off(int'(N_DIGITS), ACTIVE_LOW != 0);
  localparam logic [N_DIGITS-1:0]   OFF     = OFF_ALL[N_DIGITS-1:0];

  // First enabled digit strictly after cur, wrapping; cur itself if it is the only one.
  function automatic logic [SW-1:0] next_digit(input logic [SW-1:0] cur,
                                               input logic [N_DIGITS-1:0] mask);
    logic [SW-1:0] idx;
    logic          found;
    next_digit = cur;
    idx        = cur;
    found      = 1'b0;
    for (int k = 0; k < int'(N_DIGITS); k++) begin
      idx = (idx == SW'(N_DIGITS - 1)) ? '0 : idx + 1'b1;
      if (!found && mask[idx]) begin
        next_digit = idx;
        found      = 1'b1;
      end
    end
  endfunction

  scan_state_t         state, state_nxt;
  logic [SW-1:0]       sel_nxt;
  logic [SW-1:0]       lowest;
  logic                tick_nxt;
  logic                lit;
  logic [N_DIGITS-1:0] anodos_nxt;
  logic                tmr_clr;
  logic                dead_done;
  logic                slot_last;
  logic [BRIGHT_W-1:0] pwm_phase_c;
  logic                pwm_ok;

  scan_slot_timer #(
    .SLOT_CYCLES (SLOT_CYCLES),
    .DEAD_CYCLES (DEAD_CYCLES),
    .BRIGHT_W    (BRIGHT_W)
  ) u_timer (
    .clk         (clk),
    .rst         (rst),
    .clr         (tmr_clr),
    .en          (!tmr_clr),
    .dead_done   (dead_done),
    .slot_last   (slot_last),
    .pwm_phase_c (pwm_phase_c)
  );

`ifdef DIGIT_SCAN_PWM_EN
  assign pwm_ok = (pwm_phase_c <= brightness);
`else
  logic unused_pwm;
  assign unused_pwm = ^{pwm_phase_c, brightness};
  assign pwm_ok     = 1'b1;
`endif

  // Next state, next digit and the values the output registers will take.
  always_comb begin
    state_nxt = state;
    sel_nxt   = anode_sel;
    tick_nxt  = 1'b0;
    lowest    = next_digit(SW'(N_DIGITS - 1), digit_mask);
    case (state)
      IDLE: begin
        if (en && (|digit_mask)) begin
          state_nxt = DEAD;
          sel_nxt   = lowest;
          tick_nxt  = 1'b1;
        end
      end
      DEAD: begin
        if (!en)            state_nxt = IDLE;
        else if (dead_done) state_nxt = ON;
      end
      ON: begin
        if (!en) begin
          state_nxt = IDLE;
        end else if (slot_last) begin
          if (digit_mask == '0) begin
            state_nxt = IDLE;
          end else begin
            state_nxt = DEAD;
            sel_nxt   = next_digit(anode_sel, digit_mask);
            tick_nxt  = (sel_nxt == lowest);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    tmr_clr    = (state == IDLE) || (state_nxt == IDLE);
    lit        = (state_nxt == ON) && pwm_ok;
    anodos_nxt = lit ? (OFF ^ (N_DIGITS'(1) << sel_nxt)) : OFF;
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      anode_sel  <= '0;
      anodos     <= OFF;
      blank      <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      state      <= state_nxt;
      anode_sel  <= sel_nxt;
      anodos     <= anodos_nxt;
      blank      <= !lit;
      frame_tick <= tick_nxt;
    end
  end

endmodule

// File: tb/tb_digit_scan_driver.sv
// Directed scoreboard bench for digit_scan_driver: a 4-digit common-anode
// instance and a 5-digit active-high instance share clock and reset.
module tb_digit_scan_driver;

  localparam int SLOT = 32;
  localparam int DEAD = 2;
`ifdef DIGIT_SCAN_PWM_EN
  localparam bit PWM = 1'b1;
`else
  localparam bit PWM = 1'b0;
`endif

  typedef struct packed {
    logic [3:0]  sel;
    logic [15:0] an;
    logic        blank;
    logic        tick;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en4 = 1'b0, en5 = 1'b0;
  logic [3:0] mask4 = 4'hF, bright4 = 4'hF;
  logic [4:0] mask5 = 5'h00;
  logic [3:0] bright5 = 4'h3;
  logic [1:0] sel4;
  logic [3:0] an4;
  logic       blank4, tick4;
  logic [2:0] sel5;
  logic [4:0] an5;
  logic       blank5, tick5;

  int   n_total = 0;
  int   n_bad   = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  digit_scan_driver #(.N_DIGITS(4), .SLOT_CYCLES(SLOT), .DEAD_CYCLES(DEAD),
                      .ACTIVE_LOW(1), .BRIGHT_W(4)) dut4 (
    .clk(clk), .rst(rst), .en(en4), .digit_mask(mask4), .brightness(bright4),
    .anode_sel(sel4), .anodos(an4), .blank(blank4), .frame_tick(tick4));

  digit_scan_driver #(.N_DIGITS(5), .SLOT_CYCLES(SLOT), .DEAD_CYCLES(DEAD),
                      .ACTIVE_LOW(0), .BRIGHT_W(4)) dut5 (
    .clk(clk), .rst(rst), .en(en5), .digit_mask(mask5), .brightness(bright5),
    .anode_sel(sel5), .anodos(an5), .blank(blank5), .frame_tick(tick5));

  function automatic logic [15:0] off_of(input int which);
    return (which == 4) ? 16'h000F : 16'h0000;
  endfunction

  // Expected outputs p cycles after scanning starts, from the slot/frame layout.
  function automatic exp_t model(input int n, input logic [15:0] mask, input int bright,
                                 input int p, input logic [15:0] off);
    int   list[16];
    int   cnt;
    int   s, c, d;
    bit   on;
    exp_t e;
    cnt = 0;
    for (int i = 0; i < n; i++) if (mask[i]) begin list[cnt] = i; cnt++; end
    s  = p / SLOT;
    c  = p % SLOT;
    d  = list[s % cnt];
    on = (c >= DEAD) && (!PWM || ((c % 16) <= bright));
    e.sel   = 4'(d);
    e.an    = on ? (off ^ (16'd1 << d)) : off;
    e.blank = !on;
    e.tick  = (c == 0) && ((s % cnt) == 0);
    return e;
  endfunction

  function automatic exp_t obs(input int which);
    exp_t o;
    if (which == 4) o = {4'(sel4), 16'(an4), blank4, tick4};
    else            o = {4'(sel5), 16'(an5), blank5, tick5};
    return o;
  endfunction

  task automatic check(input int which, input exp_t e, input string tag, input int p);
    exp_t o;
    o = obs(which);
    n_total++;
    assert (o === e) else begin
      n_bad++;
      $error("FAIL %s dut%0d p=%0d observed sel=%0d an=%h blank=%b tick=%b expected sel=%0d an=%h blank=%b tick=%b",
             tag, which, p, o.sel, o.an, o.blank, o.tick, e.sel, e.an, e.blank, e.tick);
    end
    n_total++;
    assert (o.blank === (o.an == off_of(which))) else begin
      n_bad++;
      $error("FAIL %s_blank dut%0d p=%0d observed blank=%b an=%h expected blank=%b",
             tag, which, p, o.blank, o.an, (o.an == off_of(which)));
    end
  endtask

  task automatic tick_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int which, input logic [15:0] mask, input int bright,
                     input int p0, input int ncyc, input string tag);
    exp_t e;
    int   n;
    n = (which == 4) ? 4 : 5;
    for (int i = 0; i < ncyc; i++) sb.push_back(model(n, mask, bright, p0 + i, off_of(which)));
    for (int i = 0; i < ncyc; i++) begin
      tick_clk();
      e = sb.pop_front();
      check(which, e, tag, p0 + i);
    end
  endtask

  task automatic expect_idle(input int which, input int sel, input int ncyc, input string tag);
    exp_t e;
    for (int i = 0; i < ncyc; i++) sb.push_back({4'(sel), off_of(which), 1'b1, 1'b0});
    for (int i = 0; i < ncyc; i++) begin
      tick_clk();
      e = sb.pop_front();
      check(which, e, tag, i);
    end
  endtask

  task automatic check_reset(input string tag);
    check(4, {4'd0, 16'h000F, 1'b1, 1'b0}, tag, -1);
    check(5, {4'd0, 16'h0000, 1'b1, 1'b0}, tag, -1);
  endtask

  initial begin
    // Reset values, both asynchronously and across a clock edge.
    #1 rst = 1'b1;
    #1 check_reset("reset_async");
    @(posedge clk); #1;
    check_reset("reset_held");
    #2 rst = 1'b0;
    expect_idle(4, 0, 2, "idle_after_reset");

    // Full mask at full brightness, over one frame into digit 2.
    en4 = 1'b1;
    run(4, 16'hF, 15, 0, 200, "scan_f");
    // Drop enable mid-ON on digit 2: blanked with anode_sel held.
    en4 = 1'b0;
    expect_idle(4, 2, 2, "en_drop");
    // Re-enable: restart at digit 0 one cycle later.
    en4 = 1'b1;
    run(4, 16'hF, 15, 0, 40, "reenable");
    en4 = 1'b0;
    expect_idle(4, 1, 1, "en_drop2");

    // Sparse mask: digits 1 and 3 only, 64-cycle frame.
    mask4 = 4'b1010;
    en4 = 1'b1;
    run(4, 16'hA, 15, 0, 140, "mask_a");
    en4 = 1'b0;
    expect_idle(4, 1, 1, "en_drop3");

    // Dimmed: brightness 3.
    mask4 = 4'hF; bright4 = 4'h3;
    en4 = 1'b1;
    run(4, 16'hF, 3, 0, 64, "pwm3");
    en4 = 1'b0;
    expect_idle(4, 1, 1, "en_drop4");

    // Mask cleared mid-slot: digit 1 finishes its slot, then idle.
    bright4 = 4'hF;
    en4 = 1'b1;
    run(4, 16'hF, 15, 0, 41, "mask0_pre");
    mask4 = 4'h0;
    run(4, 16'hF, 15, 41, 23, "mask0_finish");
    expect_idle(4, 1, 3, "mask0_idle");

    // Asynchronous reset during DEAD on digit 2.
    mask4 = 4'b0100;
    run(4, 16'h4, 15, 0, 1, "pre_rst");
    #1 rst = 1'b1;
    #1 check_reset("rst_mid_dead");
    #2 rst = 1'b0;
    mask4 = 4'hF;
    run(4, 16'hF, 15, 0, 4, "post_rst");
    en4 = 1'b0;

    // Five active-high digits, wrap from 4 back to 0.
    mask5 = 5'h1F;
    en5 = 1'b1;
    run(5, 16'h1F, 3, 0, 200, "five_digit");
    en5 = 1'b0;
    expect_idle(5, 1, 1, "five_drop");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
